// File: rtl/dct_batch_scheduler.sv
// Batch scheduler for the DCT engine array: holds the engines in reset, releases them once
// per MCU group and rotates their output through a ring of buffers.
module dct_batch_scheduler #(
    parameter int GROUPS_PER_BUFFER = 8,
    parameter int NUM_OUT_BUFS      = 4,
    parameter int RESET_CYCLES      = 3,
    localparam int GW = (GROUPS_PER_BUFFER > 1) ? $clog2(GROUPS_PER_BUFFER) : 1,
    localparam int BW = (NUM_OUT_BUFS > 1) ? $clog2(NUM_OUT_BUFS) : 1,
    localparam int OW = $clog2(NUM_OUT_BUFS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ingester_frontbuffer_select,
    input  logic          dcts_finished,
    input  logic          outbuf_release,
    input  logic          error_clear,
    output logic [GW-1:0] mcu_groups_processed,
    output logic [BW-1:0] dcts_frontbuffer,
    output logic [OW-1:0] outbuf_count,
    output logic          dct_nreset,
    output logic          frame_done,
    output logic          overrun,
    output logic [2:0]    dbg_state
);
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    // dbg_state encoding: 0 IDLE, 1 STALL, 2 HOLD, 3 ACTIVE, 4 ERROR
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STALL  = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS_PER_BUFFER - 1);
    localparam logic [BW-1:0] LAST_BUF   = BW'(NUM_OUT_BUFS - 1);
    localparam logic [OW-1:0] FULL_COUNT = OW'(NUM_OUT_BUFS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic [2:0]    r_state;
    logic [HW-1:0] r_hold;
    logic [GW-1:0] r_groups;
    logic [BW-1:0] r_fb;
    logic [OW-1:0] r_count;
    logic          r_frame_done;
    logic          r_overrun;

    logic          w_swap;
    logic          w_full;
    logic          w_finish;
    logic          w_release;
    logic          w_last_group;
    logic          w_hold_done;
    logic [BW-1:0] w_fb_inc;
    logic [OW-1:0] w_count_next;

    assign w_swap       = r_sync0 ^ r_sync1;
    assign w_full       = (r_count == FULL_COUNT);
    // A swap in ACTIVE wins over a finish, so the finish must not touch the ring.
    assign w_finish     = (r_state == S_ACTIVE) && !w_swap && dcts_finished;
    assign w_release    = outbuf_release && (r_count != '0);
    assign w_last_group = (r_groups == LAST_GROUP);
    assign w_hold_done  = (r_hold == HOLD_LAST);
    assign w_fb_inc     = (r_fb == LAST_BUF) ? '0 : r_fb + BW'(1);

    always_comb begin
        w_count_next = r_count;
        if (w_finish && !w_release) begin
            w_count_next = r_count + OW'(1);
        end else if (!w_finish && w_release) begin
            w_count_next = r_count - OW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync0      <= 1'b0;
            r_sync1      <= 1'b0;
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_groups     <= '0;
            r_fb         <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync0      <= ingester_frontbuffer_select;
            r_sync1      <= r_sync0;
            r_count      <= w_count_next;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_groups <= '0;
                    r_hold   <= '0;
                    if (w_swap) begin
                        r_state <= w_full ? S_STALL : S_HOLD;
                    end
                end
                S_STALL: begin
                    r_hold <= '0;
                    if (w_swap) begin
                        r_state   <= S_ERROR;
                        r_overrun <= 1'b1;
                    end else if (!w_full) begin
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_swap) begin
                        r_state   <= S_ERROR;
                        r_overrun <= 1'b1;
                    end else if (w_hold_done) begin
                        r_state <= S_ACTIVE;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                S_ACTIVE: begin
                    r_hold <= '0;
                    if (w_swap) begin
                        r_state   <= S_ERROR;
                        r_overrun <= 1'b1;
                    end else if (w_finish) begin
                        r_fb <= w_fb_inc;
                        if (w_last_group) begin
                            r_groups     <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_groups <= r_groups + GW'(1);
                            r_state  <= (w_count_next == FULL_COUNT) ? S_STALL : S_HOLD;
                        end
                    end
                end
                S_ERROR: begin
                    // Clearing discards the partially written buffer by skipping its slot.
                    if (error_clear) begin
                        r_state   <= S_IDLE;
                        r_groups  <= '0;
                        r_fb      <= w_fb_inc;
                        r_overrun <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mcu_groups_processed = r_groups;
    assign dcts_frontbuffer     = r_fb;
    assign outbuf_count         = r_count;
    assign dct_nreset           = (r_state == S_ACTIVE);
    assign frame_done           = r_frame_done;
    assign overrun              = r_overrun;
    assign dbg_state            = r_state;

endmodule
